// File: rtl/clock_source_controller_pkg.sv
// Shared types and defaults for the PSI / ring-oscillator clock source controller.
// State encoding, parameter defaults and the fail counter helper.
package clock_source_controller_pkg;

  typedef enum logic [1:0] {
    POWERUP = 2'd0,
    LOCK    = 2'd1,
    RUN     = 2'd2,
    FAIL    = 2'd3
  } state_t;

  localparam int TIMEOUT_DEF        = 255;
  localparam int MIN_PERIOD_DEF     = 4;
  localparam int POWERUP_CYCLES_DEF = 1024;
  localparam int GOOD_EDGES_DEF     = 4;
  localparam int CNT_W_DEF          = 8;
  localparam int FAIL_CNT_W         = 8;

  function automatic logic [FAIL_CNT_W-1:0] sat_inc(
    input logic [FAIL_CNT_W-1:0] v
  );
    return (&v) ? v : v + FAIL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/clock_source_controller_ro_period_monitor.sv
// Measures ring-oscillator periods in clk cycles and qualifies each rise.
// A reference rise is needed before any period can be judged.
module ro_period_monitor
  import clock_source_controller_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             noise_less_ro,
  output logic             valid,
  output logic             invalid,
  output logic [CNT_W-1:0] last_period
);

  logic             ro_prev;
  logic             have_ref;
  logic             rise;
  logic             timeout;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W:0]   period;

  assign rise    = noise_less_ro & ~ro_prev;
  assign period  = {1'b0, period_cnt} + (CNT_W+1)'(1);
  assign timeout = (period_cnt == CNT_W'(TIMEOUT-1)) & ~rise;

  assign valid = rise & have_ref
               & (period >= (CNT_W+1)'(MIN_PERIOD))
               & (period_cnt < CNT_W'(TIMEOUT));

  assign invalid = (rise & have_ref & ~valid) | timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      ro_prev     <= 1'b0;
      period_cnt  <= '0;
      have_ref    <= 1'b0;
      last_period <= '0;
    end else begin
      ro_prev <= noise_less_ro;
      if (rise) begin
        period_cnt  <= '0;
        last_period <= period[CNT_W-1:0];
        have_ref    <= 1'b1;
      end else begin
        if (period_cnt != CNT_W'(TIMEOUT))
          period_cnt <= period_cnt + CNT_W'(1);
        if (timeout)
          have_ref <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_source_controller.sv
// Selects PSI or the external RO clock via power/fail mux selects.
// Locks after GOOD_EDGES clean periods, falls back on any bad period.
module clock_source_controller
  import clock_source_controller_pkg::*;
#(
  parameter int TIMEOUT        = TIMEOUT_DEF,
  parameter int MIN_PERIOD     = MIN_PERIOD_DEF,
  parameter int POWERUP_CYCLES = POWERUP_CYCLES_DEF,
  parameter int GOOD_EDGES     = GOOD_EDGES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  noise_less_ro,
  output logic                  power,
  output logic                  fail,
  output logic                  locked,
  output logic [FAIL_CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0]      last_period
);

  localparam int PU_W   = $clog2(POWERUP_CYCLES + 1);
  localparam int GOOD_W = $clog2(GOOD_EDGES + 1);

  state_t            state;
  state_t            next_state;
  logic [PU_W-1:0]   pu_cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic              valid;
  logic              invalid;
  logic              pu_done;
  logic              good_done;

  ro_period_monitor #(
    .TIMEOUT    (TIMEOUT),
    .MIN_PERIOD (MIN_PERIOD),
    .CNT_W      (CNT_W)
  ) u_mon (
    .clk           (clk),
    .rst           (rst),
    .noise_less_ro (noise_less_ro),
    .valid         (valid),
    .invalid       (invalid),
    .last_period   (last_period)
  );

  assign pu_done   = pu_cnt == PU_W'(POWERUP_CYCLES-1);
  assign good_done = valid
                   & (good_cnt == GOOD_W'(GOOD_EDGES-1));

  always_ff @(posedge clk) begin
    if (rst) state <= POWERUP;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      POWERUP: if (pu_done)   next_state = LOCK;
      LOCK:    if (good_done) next_state = RUN;
      RUN:     if (invalid)   next_state = FAIL;
      FAIL:    if (good_done) next_state = RUN;
    endcase
  end

  always_comb begin
    power  = 1'b0;
    fail   = 1'b0;
    locked = 1'b0;
    unique case (state)
      POWERUP: power  = 1'b1;
      LOCK:    power  = 1'b1;
      RUN:     locked = 1'b1;
      FAIL:    fail   = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pu_cnt <= '0;
    end else if (state == POWERUP && !pu_done) begin
      pu_cnt <= pu_cnt + PU_W'(1);
    end
  end

  // Edges seen during POWERUP never count toward lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt <= '0;
    end else begin
      unique case (state)
        LOCK, FAIL: begin
          if (invalid || good_done)
            good_cnt <= '0;
          else if (valid)
            good_cnt <= good_cnt + GOOD_W'(1);
        end
        default: good_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_count <= '0;
    end else if (state == RUN && invalid) begin
      fail_count <= sat_inc(fail_count);
    end
  end

endmodule

// File: tb/tb_clock_source_controller.sv
// Scenario bench for clock_source_controller with POWERUP_CYCLES=16.
// Inputs change on negedge; outputs are sampled on negedge.
`timescale 1ns/1ps
module tb_clock_source_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       noise_less_ro;
  logic       power;
  logic       fail;
  logic       locked;
  logic [7:0] fail_count;
  logic [7:0] last_period;

  int   checks   = 0;
  int   failures = 0;
  logic bad_seen = 1'b0;

  typedef struct packed {
    logic       power;
    logic       fail;
    logic       locked;
    logic [7:0] fcnt;
    logic [7:0] lp;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  clock_source_controller #(
    .TIMEOUT        (255),
    .MIN_PERIOD     (4),
    .POWERUP_CYCLES (16),
    .GOOD_EDGES     (4),
    .CNT_W          (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .noise_less_ro (noise_less_ro),
    .power         (power),
    .fail          (fail),
    .locked        (locked),
    .fail_count    (fail_count),
    .last_period   (last_period)
  );

  always @(negedge clk) begin
    if (((power & fail) | ~(power | fail | locked)) === 1'b1)
      bad_seen = 1'b1;
  end

  function automatic exp_t obs();
    return {power, fail, locked, fail_count, last_period};
  endfunction

  function automatic string fmt(exp_t v);
    return $sformatf("pwr=%b fail=%b lock=%b fcnt=%0d lp=%0d",
                     v.power, v.fail, v.locked, v.fcnt, v.lp);
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(int p);
    noise_less_ro = 1'b1;
    tick(p / 2);
    noise_less_ro = 1'b0;
    tick(p - p / 2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    noise_less_ro = 1'b0;
    sb.push_back({1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
    tick(2);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL reset: got %s want %s", fmt(obs()), fmt(e));
    end
  endtask

  task automatic test_powerup_lock();
    rst = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      pulse(10);
      checks++;
      if ({power, fail, locked} !== 3'b100) begin
        failures++;
        $display("FAIL qualify_%0d: got pfl=%b want 100",
                 j, {power, fail, locked});
      end
    end
    sb.push_back({1'b0, 1'b0, 1'b1, 8'd0, 8'd10});
    noise_less_ro = 1'b1;
    tick(1);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL first_lock: got %s want %s", fmt(obs()), fmt(e));
    end
    tick(4);
    noise_less_ro = 1'b0;
    tick(5);
  endtask

  task automatic test_timeout();
    noise_less_ro = 1'b0;
    tick(245);
    checks++;
    if ({power, fail, locked} !== 3'b001) begin
      failures++;
      $display("FAIL pre_timeout: got pfl=%b want 001",
               {power, fail, locked});
    end
    sb.push_back({1'b0, 1'b1, 1'b0, 8'd1, 8'd10});
    tick(1);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL timeout: got %s want %s", fmt(obs()), fmt(e));
    end
  endtask

  task automatic test_recover();
    for (int j = 1; j <= 4; j++) begin
      pulse(10);
      checks++;
      if ({power, fail, locked} !== 3'b010) begin
        failures++;
        $display("FAIL recover_wait_%0d: got pfl=%b want 010",
                 j, {power, fail, locked});
      end
    end
    sb.push_back({1'b0, 1'b0, 1'b1, 8'd1, 8'd10});
    noise_less_ro = 1'b1;
    tick(1);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL recover: got %s want %s", fmt(obs()), fmt(e));
    end
    tick(4);
    noise_less_ro = 1'b0;
    tick(5);
  endtask

  task automatic test_glitch_run();
    pulse(2);
    checks++;
    if ({power, fail, locked} !== 3'b001) begin
      failures++;
      $display("FAIL pre_glitch: got pfl=%b want 001",
               {power, fail, locked});
    end
    sb.push_back({1'b0, 1'b1, 1'b0, 8'd2, 8'd2});
    noise_less_ro = 1'b1;
    tick(1);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL glitch_run: got %s want %s", fmt(obs()), fmt(e));
    end
    noise_less_ro = 1'b0;
    tick(9);
    repeat (3) pulse(10);
    sb.push_back({1'b0, 1'b0, 1'b1, 8'd2, 8'd10});
    pulse(10);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL glitch_relock: got %s want %s", fmt(obs()), fmt(e));
    end
  endtask

  task automatic test_min_period();
    pulse(4);
    noise_less_ro = 1'b1;
    tick(1);
    checks++;
    if ({power, fail, locked, last_period} !== {3'b001, 8'd4}) begin
      failures++;
      $display("FAIL period_4: got pfl=%b lp=%0d want 001 lp=4",
               {power, fail, locked}, last_period);
    end
    tick(1);
    noise_less_ro = 1'b0;
    tick(1);
    sb.push_back({1'b0, 1'b1, 1'b0, 8'd3, 8'd3});
    noise_less_ro = 1'b1;
    tick(1);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL period_3: got %s want %s", fmt(obs()), fmt(e));
    end
    noise_less_ro = 1'b0;
    tick(9);
    repeat (4) pulse(10);
    checks++;
    if ({locked, fail_count} !== {1'b1, 8'd3}) begin
      failures++;
      $display("FAIL period_relock: got lock=%b fcnt=%0d want 1 3",
               locked, fail_count);
    end
  endtask

  task automatic test_reset_mid();
    noise_less_ro = 1'b0;
    rst = 1'b1;
    sb.push_back({1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
    tick(1);
    rst = 1'b0;
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL reset_mid: got %s want %s", fmt(obs()), fmt(e));
    end
  endtask

  task automatic test_glitch_lock();
    repeat (3) pulse(10);
    pulse(2);
    repeat (4) pulse(10);
    checks++;
    if ({power, fail, locked} !== 3'b100) begin
      failures++;
      $display("FAIL lock_glitch_hold: got pfl=%b want 100",
               {power, fail, locked});
    end
    sb.push_back({1'b0, 1'b0, 1'b1, 8'd0, 8'd10});
    pulse(10);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL lock_glitch: got %s want %s", fmt(obs()), fmt(e));
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      pulse(2);
      repeat (5) pulse(10);
      if (i == 254) begin
        checks++;
        if (fail_count !== 8'd255) begin
          failures++;
          $display("FAIL sat_reach: got fcnt=%0d want 255", fail_count);
        end
      end
    end
    sb.push_back({1'b0, 1'b0, 1'b1, 8'd255, 8'd10});
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL saturation: got %s want %s", fmt(obs()), fmt(e));
    end
    checks++;
    if (bad_seen !== 1'b0) begin
      failures++;
      $display("FAIL select_excl: got bad=%b want 0", bad_seen);
    end
  endtask

  initial begin
    test_reset();
    test_powerup_lock();
    test_timeout();
    test_recover();
    test_glitch_run();
    test_min_period();
    test_reset_mid();
    test_glitch_lock();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
